// File: rtl/sevenseg_pkg.sv
// Shared types and the hex-to-segment decode table for the multiplexed 7-segment driver.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  // Segment order is {a,b,c,d,e,f,g}, active-high.
  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'h7E;
      4'h1:    return 7'h30;
      4'h2:    return 7'h6D;
      4'h3:    return 7'h79;
      4'h4:    return 7'h33;
      4'h5:    return 7'h5B;
      4'h6:    return 7'h5F;
      4'h7:    return 7'h70;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h73;
      4'hA:    return 7'h77;
      4'hB:    return 7'h1F;
      4'hC:    return 7'h4E;
      4'hD:    return 7'h3D;
      4'hE:    return 7'h4F;
      default: return 7'h47;
    endcase
  endfunction

endpackage

// File: rtl/sevenseg_scan_timer.sv
// Slot timing for the scan driver: tick/digit counters, end-of-frame flag and PWM on-window.
module sevenseg_scan_timer #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int BRIGHT_W    = 3,
  parameter int DIG_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BRIGHT_W-1:0] brightness,
  output logic [DIG_W-1:0]    digit,
  output logic                frame_end,
  output logic                on_window
);

  localparam int TICK_W = $clog2(REFRESH_DIV);
  localparam int RD_W   = $clog2(REFRESH_DIV + 1);
  localparam int PROD_W = BRIGHT_W + 1 + RD_W;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(REFRESH_DIV - 1);
  localparam logic [DIG_W-1:0]  DIGIT_LAST = DIG_W'(NUM_DIGITS - 1);

  logic [TICK_W-1:0] tick;
  logic              tick_wrap;
  logic              digit_wrap;
  logic [PROD_W-1:0] on_count;

  assign tick_wrap  = (tick == TICK_LAST);
  assign digit_wrap = (digit == DIGIT_LAST);
  assign frame_end  = tick_wrap && digit_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick  <= '0;
      digit <= '0;
    end else if (tick_wrap) begin
      tick  <= '0;
      digit <= digit_wrap ? '0 : digit + DIG_W'(1);
    end else begin
      tick <= tick + TICK_W'(1);
    end
  end

  // Product is kept at full width so the top brightness code yields exactly REFRESH_DIV.
  assign on_count  = ((PROD_W'(brightness) + PROD_W'(1)) * PROD_W'(REFRESH_DIV)) >> BRIGHT_W;
  assign on_window = (PROD_W'(tick) < on_count);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed N-digit hex display driver with tear-free frame loading, leading-zero
// blanking, per-digit decimal points, PWM brightness and selectable pin polarity.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int BRIGHT_W       = 3,
  parameter bit ACTIVE_LOW_SEG = 1'b0,
  parameter bit ACTIVE_LOW_AN  = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam seg_t                  SEG_POL = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
  localparam logic                  DP_POL  = ACTIVE_LOW_SEG;
  localparam logic [NUM_DIGITS-1:0] AN_POL  = ACTIVE_LOW_AN ? '1 : '0;

  logic [DIG_W-1:0]        digit;
  logic                    frame_end;
  logic                    on_window;
  logic                    xfer;
  logic [4*NUM_DIGITS-1:0] pend_value;
  logic [4*NUM_DIGITS-1:0] disp_value;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    zero_above;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  seg_t                    seg_raw;
  logic [NUM_DIGITS-1:0]   an_raw;

  sevenseg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BRIGHT_W    (BRIGHT_W),
    .DIG_W       (DIG_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .brightness (brightness),
    .digit      (digit),
    .frame_end  (frame_end),
    .on_window  (on_window)
  );

  assign xfer       = load_valid && load_ready;
  assign frame_done = frame_end;

  // Display only changes at the frame boundary, so a frame is never torn; a load landing
  // on that same edge stays pending for the following frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_value <= '0;
      pend_dp    <= '0;
      disp_value <= '0;
      disp_dp    <= '0;
      load_ready <= 1'b1;
    end else begin
      if (xfer) begin
        pend_value <= load_value;
        pend_dp    <= load_dp;
      end
      if (frame_end) begin
        disp_value <= pend_value;
        disp_dp    <= pend_dp;
      end
      if (xfer) begin
        load_ready <= 1'b0;
      end else if (frame_end) begin
        load_ready <= 1'b1;
      end
    end
  end

  always_comb begin
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above  = zero_above && (disp_value[4*i +: 4] == 4'h0);
      lz_blank[i] = blank_lz && zero_above;
    end
  end

  always_comb begin
    cur_nib   = disp_value[3:0];
    cur_dp    = disp_dp[0];
    cur_blank = 1'b0;
    an_raw    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit == DIG_W'(i)) begin
        cur_nib   = disp_value[4*i +: 4];
        cur_dp    = disp_dp[i];
        cur_blank = lz_blank[i];
        an_raw[i] = on_window;
      end
    end
    seg_raw = cur_blank ? SEG_BLANK : hex_to_seg(cur_nib);
  end

  // Polarity is applied only at the pins, so idle levels follow it as well.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= SEG_POL;
      dp  <= DP_POL;
      an  <= AN_POL;
    end else begin
      seg <= seg_raw ^ SEG_POL;
      dp  <= cur_dp ^ DP_POL;
      an  <= an_raw ^ AN_POL;
    end
  end

endmodule
